// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
// Shared constants and types for the 16x32 register file writeback path.
//   DATA_W   : register data width
//   ADDR_W   : register address width
//   NUM_REGS : number of architectural registers (r0 reads as zero)
//   wb_src_e : identifies which writeback source owns the write port
// -----------------------------------------------------------------------------
package regfile_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 4;
    localparam int NUM_REGS = 1 << ADDR_W;

    typedef enum logic {
        WB_SRC_ALU = 1'b0,
        WB_SRC_MEM = 1'b1
    } wb_src_e;

endpackage : regfile_pkg

// File: rtl/wb_rr_arbiter.sv
// -----------------------------------------------------------------------------
// wb_rr_arbiter
// Two-way round-robin arbiter for the register file write port. A lone
// requester is always granted; when both request, the source that did not win
// last time is granted.
//   clk          : clock
//   reset        : synchronous active-high reset (last grant returns to ALU)
//   alu_valid_i  : ALU writeback request
//   mem_valid_i  : load writeback request
//   alu_grant_o  : ALU request accepted this cycle (combinational)
//   mem_grant_o  : load request accepted this cycle (combinational)
// -----------------------------------------------------------------------------
module wb_rr_arbiter
    import regfile_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic alu_valid_i,
    input  logic mem_valid_i,
    output logic alu_grant_o,
    output logic mem_grant_o
);

    wb_src_e last_grant_q;
    wb_src_e last_grant_d;

    // Grants depend only on the valids and the last winner, never on issue
    // state, so the execute/memory stages see no combinational path from issue.
    assign alu_grant_o = alu_valid_i & (~mem_valid_i | (last_grant_q == WB_SRC_MEM));
    assign mem_grant_o = mem_valid_i & (~alu_valid_i | (last_grant_q == WB_SRC_ALU));

    // NOTE: every variable written in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        last_grant_d = last_grant_q;
        if (alu_grant_o) begin
            last_grant_d = WB_SRC_ALU;
        end else if (mem_grant_o) begin
            last_grant_d = WB_SRC_MEM;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples its next-state value from before the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q <= WB_SRC_ALU;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule : wb_rr_arbiter

// File: rtl/regfile_wb_scheduler.sv
// -----------------------------------------------------------------------------
// regfile_wb_scheduler
// Shares the register file write port between ALU and load writebacks and
// keeps a busy scoreboard of in-flight destinations so issue stalls on RAW/WAW.
//   clk, reset                       : clock, synchronous active-high reset
//   alu_valid/addr/data, alu_ready   : ALU writeback request / accept
//   mem_valid/addr/data, mem_ready   : load writeback request / accept
//   issue_valid/has_dest/dest/src_a/src_b : instruction at issue
//   issue_stall                      : hazard, instruction must not issue
//   rf_write_en/addr/data            : registered register file write port
//   idle                             : nothing busy and no write in flight
// -----------------------------------------------------------------------------
module regfile_wb_scheduler
    import regfile_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [ADDR_W-1:0] alu_addr,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              issue_valid,
    input  logic              issue_has_dest,
    input  logic [ADDR_W-1:0] issue_dest,
    input  logic [ADDR_W-1:0] issue_src_a,
    input  logic [ADDR_W-1:0] issue_src_b,
    output logic              issue_stall,
    output logic              rf_write_en,
    output logic [ADDR_W-1:0] rf_write_addr,
    output logic [DATA_W-1:0] rf_write_data,
    output logic              idle
);

    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic                rf_write_en_q, rf_write_en_d;
    logic [ADDR_W-1:0]   rf_write_addr_q, rf_write_addr_d;
    logic [DATA_W-1:0]   rf_write_data_q, rf_write_data_d;
    logic [ADDR_W-1:0]   wb_addr;
    logic [DATA_W-1:0]   wb_data;
    logic                wb_accept;
    logic                issue_fire;

    wb_rr_arbiter u_arb (
        .clk         (clk),
        .reset       (reset),
        .alu_valid_i (alu_valid),
        .mem_valid_i (mem_valid),
        .alu_grant_o (alu_ready),
        .mem_grant_o (mem_ready)
    );

    // At most one ready is high, so the load path selects itself when granted.
    always_comb begin
        wb_accept       = alu_ready | mem_ready;
        wb_addr         = mem_ready ? mem_addr : alu_addr;
        wb_data         = mem_ready ? mem_data : alu_data;
        rf_write_en_d   = wb_accept & (wb_addr != '0);
        rf_write_addr_d = rf_write_addr_q;
        rf_write_data_d = rf_write_data_q;
        if (rf_write_en_d) begin
            rf_write_addr_d = wb_addr;
            rf_write_data_d = wb_data;
        end
    end

    assign issue_stall = issue_valid & (busy_q[issue_src_a] | busy_q[issue_src_b] |
                                        (issue_has_dest & busy_q[issue_dest]));
    assign issue_fire  = issue_valid & ~issue_stall & issue_has_dest & (issue_dest != '0);

    // The clear happens on the same edge the register file commits; applying the
    // set afterwards lets a new issue to that register win over the clear.
    always_comb begin
        busy_d = busy_q;
        if (rf_write_en_q) begin
            busy_d[rf_write_addr_q] = 1'b0;
        end
        if (issue_fire) begin
            busy_d[issue_dest] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q          <= '0;
            rf_write_en_q   <= 1'b0;
            rf_write_addr_q <= '0;
            rf_write_data_q <= '0;
        end else begin
            busy_q          <= busy_d;
            rf_write_en_q   <= rf_write_en_d;
            rf_write_addr_q <= rf_write_addr_d;
            rf_write_data_q <= rf_write_data_d;
        end
    end

    assign rf_write_en   = rf_write_en_q;
    assign rf_write_addr = rf_write_addr_q;
    assign rf_write_data = rf_write_data_q;
    assign idle          = (busy_q == '0) & ~rf_write_en_q;

endmodule : regfile_wb_scheduler

// File: tb/tb_regfile_wb_scheduler.sv
// -----------------------------------------------------------------------------
// tb_regfile_wb_scheduler
// Directed bench: a table of writeback/arbitration vectors followed by
// hand-written sequences for scoreboard stall, set-beats-clear and reset.
// -----------------------------------------------------------------------------
module tb_regfile_wb_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        alu_valid, mem_valid;
    logic        alu_ready, mem_ready;
    logic [3:0]  alu_addr, mem_addr;
    logic [31:0] alu_data, mem_data;
    logic        issue_valid, issue_has_dest;
    logic [3:0]  issue_dest, issue_src_a, issue_src_b;
    logic        issue_stall;
    logic        rf_write_en;
    logic [3:0]  rf_write_addr;
    logic [31:0] rf_write_data;
    logic        idle;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    regfile_wb_scheduler dut (
        .clk            (clk),
        .reset          (reset),
        .alu_valid      (alu_valid),
        .alu_ready      (alu_ready),
        .alu_addr       (alu_addr),
        .alu_data       (alu_data),
        .mem_valid      (mem_valid),
        .mem_ready      (mem_ready),
        .mem_addr       (mem_addr),
        .mem_data       (mem_data),
        .issue_valid    (issue_valid),
        .issue_has_dest (issue_has_dest),
        .issue_dest     (issue_dest),
        .issue_src_a    (issue_src_a),
        .issue_src_b    (issue_src_b),
        .issue_stall    (issue_stall),
        .rf_write_en    (rf_write_en),
        .rf_write_addr  (rf_write_addr),
        .rf_write_data  (rf_write_data),
        .idle           (idle)
    );

    typedef struct {
        string       name;
        logic        av;
        logic [3:0]  aa;
        logic [31:0] ad;
        logic        mv;
        logic [3:0]  ma;
        logic [31:0] md;
        logic        exp_ar;
        logic        exp_mr;
        logic        exp_en;
        logic [3:0]  exp_addr;
        logic [31:0] exp_data;
        logic        exp_idle;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        alu_valid      = 1'b0;
        alu_addr       = '0;
        alu_data       = '0;
        mem_valid      = 1'b0;
        mem_addr       = '0;
        mem_data       = '0;
        issue_valid    = 1'b0;
        issue_has_dest = 1'b0;
        issue_dest     = '0;
        issue_src_a    = '0;
        issue_src_b    = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        // Expected values assume reset leaves last_grant = ALU and nothing busy.
        vecs[0] = '{"idle",        0, 4'd0, 32'h0,        0, 4'd0, 32'h0,    0, 0, 0, 4'd0, 32'h0,        1};
        vecs[1] = '{"alu_r3",      1, 4'd3, 32'hDEADBEEF, 0, 4'd0, 32'h0,    1, 0, 1, 4'd3, 32'hDEADBEEF, 0};
        vecs[2] = '{"quiet_hold",  0, 4'd0, 32'h0,        0, 4'd0, 32'h0,    0, 0, 0, 4'd3, 32'hDEADBEEF, 1};
        vecs[3] = '{"both_1_mem",  1, 4'd1, 32'h11,       1, 4'd2, 32'h22,   0, 1, 1, 4'd2, 32'h22,       0};
        vecs[4] = '{"both_2_alu",  1, 4'd1, 32'h11,       1, 4'd2, 32'h22,   1, 0, 1, 4'd1, 32'h11,       0};
        vecs[5] = '{"both_3_mem",  1, 4'd1, 32'h11,       1, 4'd2, 32'h22,   0, 1, 1, 4'd2, 32'h22,       0};
        vecs[6] = '{"mem_r0",      0, 4'd0, 32'h0,        1, 4'd0, 32'h1234, 0, 1, 0, 4'd2, 32'h22,       1};
        vecs[7] = '{"mem_alone",   0, 4'd0, 32'h0,        1, 4'd4, 32'h44,   0, 1, 1, 4'd4, 32'h44,       0};
        vecs[8] = '{"alu_r0",      1, 4'd0, 32'h5,        0, 4'd0, 32'h0,    1, 0, 0, 4'd4, 32'h44,       1};

        clear_inputs();
        reset = 1'b1;
        repeat (2) tick();
        check("reset_en",    {31'b0, rf_write_en}, 32'd0);
        check("reset_addr",  {28'b0, rf_write_addr}, 32'd0);
        check("reset_data",  rf_write_data, 32'd0);
        check("reset_idle",  {31'b0, idle}, 32'd1);
        reset = 1'b0;

        // Table: drive at negedge, check readies before the edge, then the
        // registered write port and idle after it.
        for (int i = 0; i < 9; i++) begin
            clear_inputs();
            alu_valid = vecs[i].av;
            alu_addr  = vecs[i].aa;
            alu_data  = vecs[i].ad;
            mem_valid = vecs[i].mv;
            mem_addr  = vecs[i].ma;
            mem_data  = vecs[i].md;
            #1;
            check({vecs[i].name, ".alu_ready"}, {31'b0, alu_ready}, {31'b0, vecs[i].exp_ar});
            check({vecs[i].name, ".mem_ready"}, {31'b0, mem_ready}, {31'b0, vecs[i].exp_mr});
            check({vecs[i].name, ".stall"},     {31'b0, issue_stall}, 32'd0);
            tick();
            check({vecs[i].name, ".wr_en"},   {31'b0, rf_write_en}, {31'b0, vecs[i].exp_en});
            check({vecs[i].name, ".wr_addr"}, {28'b0, rf_write_addr}, {28'b0, vecs[i].exp_addr});
            check({vecs[i].name, ".wr_data"}, rf_write_data, vecs[i].exp_data);
            check({vecs[i].name, ".idle"},    {31'b0, idle}, {31'b0, vecs[i].exp_idle});
        end

        // RAW: issue dest=5, dependent read stalls through the commit cycle.
        clear_inputs();
        issue_valid = 1'b1; issue_has_dest = 1'b1; issue_dest = 4'd5;
        #1 check("raw.issue_stall", {31'b0, issue_stall}, 32'd0);
        tick();
        clear_inputs();
        issue_valid = 1'b1; issue_src_a = 4'd5;
        alu_valid = 1'b1; alu_addr = 4'd5; alu_data = 32'h55;
        #1;
        check("raw.stall_n",   {31'b0, issue_stall}, 32'd1);
        check("raw.alu_ready", {31'b0, alu_ready}, 32'd1);
        check("raw.idle_n",    {31'b0, idle}, 32'd0);
        tick();
        alu_valid = 1'b0;
        #1;
        check("raw.wr_en",       {31'b0, rf_write_en}, 32'd1);
        check("raw.wr_addr",     {28'b0, rf_write_addr}, 32'd5);
        check("raw.wr_data",     rf_write_data, 32'h55);
        check("raw.stall_n1",    {31'b0, issue_stall}, 32'd1);
        tick();
        #1;
        check("raw.stall_n2",    {31'b0, issue_stall}, 32'd0);
        check("raw.wr_en_n2",    {31'b0, rf_write_en}, 32'd0);
        check("raw.idle_n2",     {31'b0, idle}, 32'd1);

        // Issue dest=7 on the edge that commits a write to (non-busy) r7.
        clear_inputs();
        alu_valid = 1'b1; alu_addr = 4'd7; alu_data = 32'h77;
        tick();
        clear_inputs();
        issue_valid = 1'b1; issue_has_dest = 1'b1; issue_dest = 4'd7;
        #1;
        check("setwin.wr_en",   {31'b0, rf_write_en}, 32'd1);
        check("setwin.wr_addr", {28'b0, rf_write_addr}, 32'd7);
        check("setwin.stall",   {31'b0, issue_stall}, 32'd0);
        tick();
        clear_inputs();
        #1 check("setwin.idle", {31'b0, idle}, 32'd0);
        issue_valid = 1'b1; issue_src_b = 4'd7;
        #1 check("setwin.busy7", {31'b0, issue_stall}, 32'd1);
        tick();

        // Build busy = {r5, r7} with a load write to r9 in flight, then reset.
        clear_inputs();
        issue_valid = 1'b1; issue_has_dest = 1'b1; issue_dest = 4'd5;
        mem_valid = 1'b1; mem_addr = 4'd9; mem_data = 32'h99;
        #1;
        check("rst.pre_stall", {31'b0, issue_stall}, 32'd0);
        check("rst.pre_mem",   {31'b0, mem_ready}, 32'd1);
        tick();
        clear_inputs();
        reset = 1'b1;
        alu_valid = 1'b1; alu_addr = 4'd3; alu_data = 32'h33;
        #1;
        check("rst.pend_en",   {31'b0, rf_write_en}, 32'd1);
        check("rst.pend_addr", {28'b0, rf_write_addr}, 32'd9);
        tick();
        reset = 1'b0;
        clear_inputs();
        #1;
        check("rst.en",   {31'b0, rf_write_en}, 32'd0);
        check("rst.addr", {28'b0, rf_write_addr}, 32'd0);
        check("rst.data", rf_write_data, 32'd0);
        check("rst.idle", {31'b0, idle}, 32'd1);
        issue_valid = 1'b1; issue_has_dest = 1'b1;
        issue_src_a = 4'd5; issue_src_b = 4'd7; issue_dest = 4'd5;
        alu_valid = 1'b1; alu_addr = 4'd1; alu_data = 32'h11;
        mem_valid = 1'b1; mem_addr = 4'd2; mem_data = 32'h22;
        #1;
        check("rst.busy_clear", {31'b0, issue_stall}, 32'd0);
        check("rst.alu_ready",  {31'b0, alu_ready}, 32'd0);
        check("rst.mem_ready",  {31'b0, mem_ready}, 32'd1);
        tick();
        clear_inputs();
        #1;
        check("rst.post_addr", {28'b0, rf_write_addr}, 32'd2);
        check("rst.post_data", rf_write_data, 32'h22);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_regfile_wb_scheduler
